// File: rtl/aes_inv_cipher_iter_if.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter_if
// Bundles the request/response signals of the iterative AES inverse cipher.
//   start      : request to decipher cipher_in (master -> slave)
//   cipher_in  : 128-bit ciphertext, byte 0 in bits [127:120]
//   round_keys : expanded key schedule, round key 0 in the top 128-bit slice
//   plain_out  : 128-bit plaintext, same byte order as cipher_in
//   busy       : operation in progress
//   done       : one-cycle pulse, plain_out valid
//   round_cnt  : current round index
// Parameter NR must match the NR of the attached cipher core.
// ---------------------------------------------------------------------------
interface aes_inv_cipher_iter_if #(
  parameter int NR = 10
);
  logic                    start;
  logic [127:0]            cipher_in;
  logic [(NR+1)*128-1:0]   round_keys;
  logic [127:0]            plain_out;
  logic                    busy;
  logic                    done;
  logic [3:0]              round_cnt;

  modport master (
    output start, cipher_in, round_keys,
    input  plain_out, busy, done, round_cnt
  );

  modport slave (
    input  start, cipher_in, round_keys,
    output plain_out, busy, done, round_cnt
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter
// Iterative FIPS-197 inverse cipher, one round per clock.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : aes_inv_cipher_iter_if.slave (start, cipher_in, round_keys in;
//           plain_out, busy, done, round_cnt out)
// Parameters: NK (key words 4/6/8), NR (rounds 10/12/14, must equal NK+6).
// Timing: the start edge loads cipher_in ^ rk[NR]; NR round edges follow, so
// done is high after the (NR+1)-th edge counting the accepting edge. The FSM
// is back in IDLE during the done cycle, so a start there is accepted.
// Optional feature macro AES_INV_RESTART_EN: when defined, start while busy
// aborts the current block and reloads; otherwise it is ignored.
// ---------------------------------------------------------------------------
module aes_inv_cipher_iter #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  aes_inv_cipher_iter_if.slave bus
);

  // A mismatched NK/NR pair never starts rather than producing garbage.
  localparam bit         CFG_OK   = (NR == NK + 6);
  localparam logic [3:0] LOAD_CNT = 4'(NR - 1);

  typedef enum logic [0:0] {IDLE, ROUND} fsm_t;

  fsm_t         fsm_reg;
  logic [127:0] state_reg;
  logic [3:0]   round_cnt_reg;
  logic         busy_reg;
  logic         done_reg;

  logic [127:0] rk [NR+1];
  logic [127:0] sub_blk;
  logic [127:0] ark_blk;
  logic [127:0] mix_blk;
  logic [127:0] load_blk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // a^254 = a^-1 in GF(2^8); 0 naturally maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int k = 2; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse affine transform first, then field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  genvar gi;

  // Round key i sits at slice (NR-i) counted from the LSB end.
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_rk
      assign rk[gi] = bus.round_keys[(NR - gi)*128 +: 128];
    end
  endgenerate

  // InvShiftRows folded into the S-box input selection: byte (row,col)
  // takes the byte from column (col-row) mod 4 of the same row.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
      assign sub_blk[127 - 8*gi -: 8] = inv_sbox(state_reg[127 - 8*SRC -: 8]);
    end
  endgenerate

  assign ark_blk  = sub_blk ^ rk[round_cnt_reg];
  assign load_blk = bus.cipher_in ^ rk[NR];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign mix_blk[127 - 32*gi -: 32] = inv_mix_col(ark_blk[127 - 32*gi -: 32]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      round_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (bus.start && CFG_OK) begin
            state_reg     <= load_blk;
            round_cnt_reg <= LOAD_CNT;
            busy_reg      <= 1'b1;
            fsm_reg       <= ROUND;
          end
        end
        ROUND: begin
`ifdef AES_INV_RESTART_EN
          if (bus.start) begin
            state_reg     <= load_blk;
            round_cnt_reg <= LOAD_CNT;
          end else
`endif
          if (round_cnt_reg == 4'd0) begin
            state_reg <= ark_blk;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            fsm_reg   <= IDLE;
          end else begin
            state_reg     <= mix_blk;
            round_cnt_reg <= round_cnt_reg - 4'd1;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign bus.plain_out = state_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.round_cnt = round_cnt_reg;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
// Self-checking bench for aes_inv_cipher_iter with NR=10/12/14 instances.
// Expected plaintexts come from a table-driven AES model (S-box tables built
// by brute-force field inversion, textbook key expansion and inverse cipher).
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_inv_cipher_iter_if #(.NR(10)) bus4 ();
  aes_inv_cipher_iter_if #(.NR(12)) bus6 ();
  aes_inv_cipher_iter_if #(.NR(14)) bus8 ();

  aes_inv_cipher_iter #(.NK(4), .NR(10)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  aes_inv_cipher_iter #(.NK(6), .NR(12)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
  aes_inv_cipher_iter #(.NK(8), .NR(14)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY4   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY6   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY8   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT4    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8    = 128'h8ea2b7ca516745bfeafc49904b496089;

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t     [256];
  logic [7:0]   inv_sbox_t [256];
  logic [31:0]  w          [60];
  logic [127:0] rk_model   [15];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256 && x != 0; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x] = s;
      inv_sbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk_model[nr][127-8*i -: 8];
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r + 4*c] = s[r + 4*((c - r + 4) % 4)];
      for (int i = 0; i < 16; i++) s[i] = inv_sbox_t[t[i]] ^ rk_model[rnd][127-8*i -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          t[0] = s[4*c]; t[1] = s[4*c+1]; t[2] = s[4*c+2]; t[3] = s[4*c+3];
          s[4*c]   = gmul(t[0],8'h0e) ^ gmul(t[1],8'h0b) ^ gmul(t[2],8'h0d) ^ gmul(t[3],8'h09);
          s[4*c+1] = gmul(t[0],8'h09) ^ gmul(t[1],8'h0e) ^ gmul(t[2],8'h0b) ^ gmul(t[3],8'h0d);
          s[4*c+2] = gmul(t[0],8'h0d) ^ gmul(t[1],8'h09) ^ gmul(t[2],8'h0e) ^ gmul(t[3],8'h0b);
          s[4*c+3] = gmul(t[0],8'h0b) ^ gmul(t[1],8'h0d) ^ gmul(t[2],8'h09) ^ gmul(t[3],8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic prep4(input logic [255:0] key, input logic [127:0] ct, output logic [127:0] exp);
    expand_key(key, 4, 10);
    for (int i = 0; i <= 10; i++) bus4.round_keys[(10-i)*128 +: 128] = rk_model[i];
    bus4.cipher_in = ct;
    exp = model_decrypt(ct, 10);
  endtask

  task automatic prep6(input logic [255:0] key, input logic [127:0] ct, output logic [127:0] exp);
    expand_key(key, 6, 12);
    for (int i = 0; i <= 12; i++) bus6.round_keys[(12-i)*128 +: 128] = rk_model[i];
    bus6.cipher_in = ct;
    exp = model_decrypt(ct, 12);
  endtask

  task automatic prep8(input logic [255:0] key, input logic [127:0] ct, output logic [127:0] exp);
    expand_key(key, 8, 14);
    for (int i = 0; i <= 14; i++) bus8.round_keys[(14-i)*128 +: 128] = rk_model[i];
    bus8.cipher_in = ct;
    exp = model_decrypt(ct, 14);
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Start all three cores together; latency counts the accepting edge as 1.
  task automatic run_all(input logic [127:0] e4, input logic [127:0] e6,
                         input logic [127:0] e8, input string tag);
    int edges, lat4, lat6, lat8;
    logic [127:0] g4, g6, g8;
    lat4 = 0; lat6 = 0; lat8 = 0; g4 = '0; g6 = '0; g8 = '0;
    @(negedge clk);
    bus4.start = 1'b1; bus6.start = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0; bus6.start = 1'b0; bus8.start = 1'b0;
    edges = 1;
    while ((lat4 == 0 || lat6 == 0 || lat8 == 0) && edges < 40) begin
      if (bus4.done && lat4 == 0) begin lat4 = edges; g4 = bus4.plain_out; end
      if (bus6.done && lat6 == 0) begin lat6 = edges; g6 = bus6.plain_out; end
      if (bus8.done && lat8 == 0) begin lat8 = edges; g8 = bus8.plain_out; end
      @(negedge clk);
      edges++;
    end
    check({tag, "_lat10"}, 128'(lat4), 128'd11);
    check({tag, "_lat12"}, 128'(lat6), 128'd13);
    check({tag, "_lat14"}, 128'(lat8), 128'd15);
    check({tag, "_pt10"}, g4, e4);
    check({tag, "_pt12"}, g6, e6);
    check({tag, "_pt14"}, g8, e8);
    $display("txn %s: lat %0d/%0d/%0d pt10=%h", tag, lat4, lat6, lat8, g4);
  endtask

  task automatic start4(input logic [127:0] ct);
    @(negedge clk);
    bus4.cipher_in = ct;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // Called one negedge after the accepting edge (e0 = edges seen so far).
  task automatic wait_done4(input int e0, output int edges, output int busy_lows);
    edges = e0;
    busy_lows = 0;
    while (!bus4.done && edges < 60) begin
      if (!bus4.busy) busy_lows++;
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] e4, e6, e8, ctb, expb;
    int edges, lows, e1, e2, dones;

    build_sbox();
    bus4.start = 1'b0; bus6.start = 1'b0; bus8.start = 1'b0;
    bus4.cipher_in = '0; bus6.cipher_in = '0; bus8.cipher_in = '0;
    bus4.round_keys = '0; bus6.round_keys = '0; bus8.round_keys = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_plain", bus4.plain_out, 128'h0);
    check("rst_busy", 128'(bus4.busy), 128'h0);
    check("rst_done", 128'(bus4.done), 128'h0);
    check("rst_cnt", 128'(bus4.round_cnt), 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vectors for all three key sizes.
    prep4(KEY4, CT4, e4);
    prep6(KEY6, CT6, e6);
    prep8(KEY8, CT8, e8);
    run_all(PT_KAT, PT_KAT, PT_KAT, "kat");

    // Random keys and blocks for all three key sizes.
    for (int k = 0; k < 4; k++) begin
      prep4(rand_key(), rand_blk(), e4);
      prep6(rand_key(), rand_blk(), e6);
      prep8(rand_key(), rand_blk(), e8);
      run_all(e4, e6, e8, $sformatf("rnd%0d", k));
    end

    // Random single blocks on NR=10 with busy, pulse width and hold checks.
    for (int k = 0; k < 10; k++) begin
      prep4(rand_key(), rand_blk(), e4);
      start4(bus4.cipher_in);
      wait_done4(1, edges, lows);
      check("r10_lat", 128'(edges), 128'd11);
      check("r10_busy_low", 128'(lows), 128'd0);
      check("r10_busy_at_done", 128'(bus4.busy), 128'd0);
      check("r10_pt", bus4.plain_out, e4);
      repeat (2) @(negedge clk);
      check("r10_done_pulse", 128'(bus4.done), 128'd0);
      check("r10_hold", bus4.plain_out, e4);
      $display("txn r10_%0d: lat %0d pt=%h", k, edges, bus4.plain_out);
    end

    // Back-to-back: start re-asserted in each done cycle.
    prep4(KEY4, CT4, e4);
    start4(CT4);
    wait_done4(1, edges, lows);
    check("b2b0_lat", 128'(edges), 128'd11);
    check("b2b0_pt", bus4.plain_out, PT_KAT);
    for (int k = 1; k <= 3; k++) begin
      bus4.start = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
      wait_done4(1, edges, lows);
      check("b2b_lat", 128'(edges), 128'd11);
      check("b2b_busy_low", 128'(lows), 128'd0);
      check("b2b_pt", bus4.plain_out, PT_KAT);
      $display("txn b2b_%0d: lat %0d pt=%h", k, edges, bus4.plain_out);
    end
    @(negedge clk);

    // Reset mid-operation at round_cnt 5.
    start4(CT4);
    edges = 1;
    while (bus4.round_cnt != 4'd5 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("rst_mid_reach5", 128'(bus4.round_cnt), 128'd5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_plain", bus4.plain_out, 128'h0);
    check("rst_mid_busy", 128'(bus4.busy), 128'h0);
    check("rst_mid_cnt", 128'(bus4.round_cnt), 128'h0);
    check("rst_mid_done", 128'(bus4.done), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus4.done) dones++;
    end
    check("rst_mid_no_done", 128'(dones), 128'd0);
    start4(CT4);
    wait_done4(1, edges, lows);
    check("rst_after_lat", 128'(edges), 128'd11);
    check("rst_after_pt", bus4.plain_out, PT_KAT);
    $display("txn reset_abort: lat %0d pt=%h", edges, bus4.plain_out);

    // start while busy, at round_cnt 7, with a different second block.
    ctb  = rand_blk();
    expb = model_decrypt(ctb, 10);
    start4(CT4);
    e1 = 1;
    while (bus4.round_cnt != 4'd7 && e1 < 20) begin
      @(negedge clk);
      e1++;
    end
    check("restart_reach7", 128'(bus4.round_cnt), 128'd7);
    bus4.cipher_in = ctb;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    e1++;
    e2 = 1;
    while (!bus4.done && e2 < 60) begin
      @(negedge clk);
      e1++;
      e2++;
    end
`ifdef AES_INV_RESTART_EN
    check("restart_lat", 128'(e2), 128'd11);
    check("restart_pt", bus4.plain_out, expb);
`else
    check("ignore_lat", 128'(e1), 128'd11);
    check("ignore_pt", bus4.plain_out, PT_KAT);
`endif
    $display("txn busy_start: lat_first %0d lat_second %0d pt=%h", e1, e2, bus4.plain_out);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 Parameter NK, default 4, key length in 32-bit words (4/6/8).
REQ-002 Parameter NR, default 10, round count (10/12/14), paired with NK.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request to decipher cipher_in; sampled on clk rising edge.
REQ-006 Port cipher_in  input  128  ciphertext block, byte 0 in bits [127:120].
REQ-007 Port round_keys  input  (NR+1)*128  expanded key schedule; round key 0 in the MSB slice [(NR+1)*128-1 -: 128], round key NR in [127:0].
REQ-008 Port plain_out  output  128  plaintext result, same byte order as cipher_in.
REQ-009 Port busy  output  1  high while an operation is in progress.
REQ-010 Port done  output  1  one-cycle pulse marking plain_out valid.
REQ-011 Port round_cnt  output  4  current round index, for the display path.

Function
REQ-012 The block SHALL implement the FIPS-197 inverse cipher, iterative, one round per clock.
REQ-013 FSM SHALL have two states, IDLE and ROUND.
REQ-014 IDLE with start=1 SHALL load state <= cipher_in ^ rk[NR] and round_cnt <= NR-1, then enter ROUND.
REQ-015 IDLE with start=0 SHALL hold all registers.
REQ-016 Each ROUND cycle with round_cnt>=1 SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk[round_cnt]) and InvMixColumns, then decrement round_cnt.
REQ-017 The ROUND cycle with round_cnt==0 SHALL apply InvShiftRows, InvSubBytes and AddRoundKey(rk[0]) with no InvMixColumns, assert done for one cycle, and return to IDLE.
REQ-018 done SHALL rise exactly NR+1 rising edges after the edge that accepted start.
REQ-019 busy SHALL be 1 from the edge after acceptance through the final round edge, and 0 in the cycle done is high.
REQ-020 plain_out SHALL drive the state register continuously; it is valid when done=1 and SHALL hold until the next accepted start.
REQ-021 The inverse S-box SHALL be computed combinationally (GF(2^8) inverse of the inverse affine transform, 0 maps to 0); 16 instances, no RAM.
REQ-022 InvMixColumns SHALL use xtime-based multiplication by 0x09, 0x0b, 0x0d and 0x0e, modulo 0x11b.
REQ-023 start asserted in the same cycle done is high SHALL be accepted (FSM is in IDLE), giving back-to-back blocks every NR+1 cycles.
REQ-024 start while busy SHALL follow the Configuration rules.
REQ-025 round_keys and cipher_in SHALL be held stable by the source for the full operation; only cipher_in is captured.

Reset
REQ-026 rst_n=0 SHALL immediately force: FSM to IDLE, state register to 0, plain_out=0, round_cnt=0, busy=0, done=0.
REQ-027 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-028 After rst_n deasserts, the first start SHALL be accepted normally.

Configuration
REQ-029 With macro AES_INV_RESTART_EN defined, start=1 while busy SHALL abort the current block and reload per REQ-014 on that edge; done SHALL then occur NR+1 edges later.
REQ-030 Without AES_INV_RESTART_EN, start=1 while busy SHALL be ignored, and the current operation SHALL complete unchanged.

Verification
REQ-031 NK=4/NR=10, key 000102..0f expanded, cipher_in 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done 11 edges later; plain_out 00112233445566778899aabbccddeeff.
REQ-032 NK=6/NR=12, key 000102..17, cipher_in dda97ca4864cdfe06eaf70a0ec0d7191 -> done after 13 edges; plain_out 00112233445566778899aabbccddeeff.
REQ-033 NK=8/NR=14, key 000102..1f, cipher_in 8ea2b7ca516745bfeafc49904b496089 -> done after 15 edges; plain_out 00112233445566778899aabbccddeeff.
REQ-034 NK=4, start re-asserted in the done cycle with the same vector -> second done exactly 11 edges later with the identical result; busy low only in each done cycle.
REQ-035 NK=4, rst_n pulsed low at round_cnt=5 -> outputs 0 immediately, no done; a new start then completes per REQ-031.
REQ-036 NK=4, start pulsed at round_cnt=7 -> without AES_INV_RESTART_EN, done 11 edges after the first start; with the macro, done 11 edges after the second start; plain_out correct in both cases.
